// File: rtl/adc_oversampler_if.sv
// Sample-in / averaged-result-out bus of the ADC oversampler.
// The master modport is the environment view: it drives samples and consumes results.
// The slave modport is the averager view.
interface adc_oversampler_if #(
    parameter int DATA_W  = 12,
    parameter int CH_BITS = 5
);
    logic [DATA_W-1:0]  sampleData;
    logic               sampleValid;
    logic [CH_BITS-1:0] sampleAddr;
    logic [DATA_W-1:0]  avgData;
    logic [CH_BITS-1:0] avgAddr;
    logic               avgValid;
    logic               avgReady;
    logic               overrun;

    modport master (
        output sampleData,
        output sampleValid,
        output sampleAddr,
        output avgReady,
        input  avgData,
        input  avgAddr,
        input  avgValid,
        input  overrun
    );

    modport slave (
        input  sampleData,
        input  sampleValid,
        input  sampleAddr,
        input  avgReady,
        output avgData,
        output avgAddr,
        output avgValid,
        output overrun
    );
endinterface

// File: rtl/adc_oversampler.sv
// Per-channel oversampling averager.
// Each mux channel address owns an accumulator and a sample counter.
// After 2^AVG_LOG2 samples the truncated mean is offered to a one-deep output register.
// That register is drained through a valid/ready handshake.
// A result that finds the register occupied and not being drained is dropped.
// The drop is flagged on the sticky overrun output.
module adc_oversampler #(
    parameter int DATA_W   = 12,
    parameter int CH_BITS  = 5,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    adc_oversampler_if.slave   bus
);

    localparam int NCH   = 1 << CH_BITS;
    localparam int ACC_W = DATA_W + AVG_LOG2;

    localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
    localparam logic [AVG_LOG2-1:0] CNT_ZERO = {AVG_LOG2{1'b0}};
    localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);
    localparam logic [ACC_W-1:0]    ACC_ZERO = {ACC_W{1'b0}};

    // Per-channel running state
    logic [ACC_W-1:0]    acc_r [NCH];
    logic [AVG_LOG2-1:0] cnt_r [NCH];

    // Output holding register
    logic [DATA_W-1:0]   avg_data_r;
    logic [CH_BITS-1:0]  avg_addr_r;
    logic                avg_valid_r;
    logic                overrun_r;

    // Datapath / control decode
    logic [CH_BITS-1:0]  ch_s;
    logic [ACC_W-1:0]    acc_cur_s;
    logic [AVG_LOG2-1:0] cnt_cur_s;
    logic [ACC_W-1:0]    sum_s;
    logic [DATA_W-1:0]   result_s;
    logic                take_s;
    logic                last_s;
    logic                complete_s;
    logic                pop_s;
    logic                load_s;
    logic                drop_s;

    // Read the addressed channel and decide completion / load / drop for this cycle
    always_comb begin
        ch_s       = bus.sampleAddr;
        acc_cur_s  = acc_r[ch_s];
        cnt_cur_s  = cnt_r[ch_s];
        // The accumulator is wide enough for the full sum, so it cannot overflow.
        sum_s      = acc_cur_s + {{AVG_LOG2{1'b0}}, bus.sampleData};
        // Truncating mean: drop the low AVG_LOG2 bits, no rounding.
        result_s   = sum_s[ACC_W-1:AVG_LOG2];
        // restart wins over a coincident sample, so that sample is never counted.
        take_s     = bus.sampleValid & ~restart;
        last_s     = (cnt_cur_s == CNT_LAST);
        complete_s = take_s & last_s;
        pop_s      = avg_valid_r & bus.avgReady;
        // The register can take a new result when it is empty or being drained this edge.
        load_s     = complete_s & (~avg_valid_r | pop_s);
        drop_s     = complete_s & avg_valid_r & ~bus.avgReady;
    end

    // Per-channel accumulate; a completing sample restarts that channel from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                acc_r[i] <= ACC_ZERO;
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (restart) begin
            for (int i = 0; i < NCH; i++) begin
                acc_r[i] <= ACC_ZERO;
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (take_s) begin
            if (last_s) begin
                acc_r[ch_s] <= ACC_ZERO;
                cnt_r[ch_s] <= CNT_ZERO;
            end else begin
                acc_r[ch_s] <= sum_s;
                cnt_r[ch_s] <= cnt_cur_s + CNT_ONE;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_r[i] <= acc_r[i];
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // One-deep result register with valid/ready drain and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg_data_r  <= {DATA_W{1'b0}};
            avg_addr_r  <= {CH_BITS{1'b0}};
            avg_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (load_s) begin
                avg_data_r  <= result_s;
                avg_addr_r  <= ch_s;
                avg_valid_r <= 1'b1;
            end else if (pop_s) begin
                // Data and address keep their last value after the transfer.
                avg_valid_r <= 1'b0;
            end else begin
                avg_valid_r <= avg_valid_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.avgData  = avg_data_r;
    assign bus.avgAddr  = avg_addr_r;
    assign bus.avgValid = avg_valid_r;
    assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_adc_oversampler.sv
// Directed, table-driven bench for adc_oversampler (DATA_W=12, CH_BITS=5, AVG_LOG2=2).
// Each table row is one clock: the inputs are driven for that cycle.
// The expected outputs are those seen just after the following rising edge.
module tb_adc_oversampler;

    logic clk = 1'b0;
    logic reset;
    logic restart;

    adc_oversampler_if #(.DATA_W(12), .CH_BITS(5)) bus ();

    adc_oversampler #(.DATA_W(12), .CH_BITS(5), .AVG_LOG2(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [4:0]  sa;
        logic [11:0] sd;
        logic        rdy;
        logic        rs;
        logic        ev;
        logic [11:0] ed;
        logic [4:0]  ea;
        logic        eo;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic sv, input logic [4:0] sa, input logic [11:0] sd,
                       input logic rdy, input logic rs, input logic ev,
                       input logic [11:0] ed, input logic [4:0] ea, input logic eo);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.rdy = rdy; v.rs = rs;
        v.ev = ev; v.ed = ed; v.ea = ea; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [11:0] ed,
                           input logic [4:0] ea, input logic eo);
        chk({tag, " avgValid"}, {31'd0, bus.avgValid}, {31'd0, ev});
        chk({tag, " avgData"},  {20'd0, bus.avgData},  {20'd0, ed});
        chk({tag, " avgAddr"},  {27'd0, bus.avgAddr},  {27'd0, ea});
        chk({tag, " overrun"},  {31'd0, bus.overrun},  {31'd0, eo});
    endtask

    // Drive one cycle of inputs, then let the edge happen and step just past it
    task automatic step(input logic sv, input logic [4:0] sa, input logic [11:0] sd,
                        input logic rdy, input logic rs);
        bus.sampleValid = sv;
        bus.sampleAddr  = sa;
        bus.sampleData  = sd;
        bus.avgReady    = rdy;
        restart         = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: ch3 100..103, ready high -> 101 on ch3 for exactly one cycle
        add(1,  3, 100, 1, 0,   0,    0,  0, 0);
        add(1,  3, 101, 1, 0,   0,    0,  0, 0);
        add(1,  3, 102, 1, 0,   0,    0,  0, 0);
        add(1,  3, 103, 1, 0,   1,  101,  3, 0);
        add(0,  0,   0, 1, 0,   0,  101,  3, 0);
        // T2: ch0 (10) and ch31 (4095) interleaved every cycle
        for (int k = 0; k < 3; k++) begin
            add(1,  0,   10, 1, 0, 0, 101, 3, 0);
            add(1, 31, 4095, 1, 0, 0, 101, 3, 0);
        end
        add(1,  0,   10, 1, 0,   1,   10,  0, 0);
        add(1, 31, 4095, 1, 0,   1, 4095, 31, 0);   // pop of ch0 and load of ch31 together
        add(0,  0,    0, 1, 0,   0, 4095, 31, 0);
        // T4: hold ch5 result (20), pop in the same cycle as ch6 completion (40)
        for (int k = 0; k < 3; k++) add(1, 5, 20, 0, 0, 0, 4095, 31, 0);
        add(1,  5,  20, 0, 0,   1,   20,  5, 0);
        for (int k = 0; k < 3; k++) add(1, 6, 40, 0, 0, 1, 20, 5, 0);
        add(1,  6,  40, 1, 0,   1,   40,  6, 0);
        add(0,  0,   0, 1, 0,   0,   40,  6, 0);
        // T5: ch7 two samples, restart with a coincident sample, then 4 x 200
        add(1,  7, 1000, 1, 0,  0,   40,  6, 0);
        add(1,  7, 1000, 1, 0,  0,   40,  6, 0);
        add(1,  7, 1000, 1, 1,  0,   40,  6, 0);
        for (int k = 0; k < 3; k++) add(1, 7, 200, 1, 0, 0, 40, 6, 0);
        add(1,  7,  200, 1, 0,  1,  200,  7, 0);
        add(0,  0,    0, 1, 0,  0,  200,  7, 0);
        // T3: ready low; ch1 (8) held, ch2 (16) dropped with overrun; then drain
        for (int k = 0; k < 3; k++) add(1, 1, 8, 0, 0, 0, 200, 7, 0);
        add(1,  1,   8, 0, 0,   1,    8,  1, 0);
        for (int k = 0; k < 3; k++) add(1, 2, 16, 0, 0, 1, 8, 1, 0);
        add(1,  2,  16, 0, 0,   1,    8,  1, 1);
        add(0,  0,   0, 0, 0,   1,    8,  1, 1);
        add(0,  0,   0, 1, 0,   0,    8,  1, 1);
        add(0,  0,   0, 1, 0,   0,    8,  1, 1);
        // restart leaves output register and overrun alone
        add(0,  0,   0, 1, 1,   0,    8,  1, 1);

        // Reset state
        reset           = 1'b0;
        restart         = 1'b0;
        bus.sampleValid = 1'b0;
        bus.sampleAddr  = 5'd0;
        bus.sampleData  = 12'd0;
        bus.avgReady    = 1'b0;
        #12;
        chk_out("reset", 1'b0, 12'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].rdy, vecs[i].rs);
            chk_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ea, vecs[i].eo);
        end

        // T6: hold a ch10 result (60), three partial ch4 samples, then async reset
        for (int k = 0; k < 4; k++) step(1'b1, 5'd10, 12'd60, 1'b0, 1'b0);
        chk_out("t6 held", 1'b1, 12'd60, 5'd10, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 5'd4, 12'd1000, 1'b0, 1'b0);
        bus.sampleValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_out("t6 async reset", 1'b0, 12'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("t6 in reset", 1'b0, 12'd0, 5'd0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5'd4, 12'd50, 1'b1, 1'b0);
            chk($sformatf("t6 post-reset partial%0d avgValid", k), {31'd0, bus.avgValid}, 32'd0);
        end
        step(1'b1, 5'd4, 12'd50, 1'b1, 1'b0);
        chk_out("t6 post-reset result", 1'b1, 12'd50, 5'd4, 1'b0);
        step(1'b0, 5'd0, 12'd0, 1'b1, 1'b0);
        chk_out("t6 drained", 1'b0, 12'd50, 5'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_oversampler.md
Name: adc_oversampler

Overview:
- Per-channel oversampling averager between the ADC SPI receiver (and its mux-address switcher) and the analog distributor.
- Accumulates 2^AVG_LOG2 consecutive samples for each mux channel address, then emits one truncated mean tagged with that address.
- Output uses a valid/ready handshake with a one-deep holding register.
- Reduces ADC noise before samples are placed into the OrbitaM8 analog stream.

Parameters:
DATA_W, 12, sample and result width
CH_BITS, 5, channel address width (2^CH_BITS channels)
AVG_LOG2, 2, log2 of samples averaged per result (1..4)

Ports:
clk  in  1  system clock (80 MHz domain)
reset  in  1  asynchronous reset, active-low
restart  in  1  synchronous clear of all accumulators/counts
sampleData  in  DATA_W  ADC sample
sampleValid  in  1  one-cycle strobe, sample and address valid
sampleAddr  in  CH_BITS  mux channel of sample
avgData  out  DATA_W  averaged result
avgAddr  out  CH_BITS  channel of result
avgValid  out  1  result held and valid
avgReady  in  1  consumer accepts result when high with avgValid
overrun  out  1  sticky: a completed result was dropped

Behaviour:
- Reset (reset=0, async):
  - All acc[ch] and cnt[ch] cleared.
  - avgData=0, avgAddr=0, avgValid=0, overrun=0.
  - Reset mid-accumulation discards partial sums; no output is produced from pre-reset samples.
- Storage:
  - acc[ch] is DATA_W+AVG_LOG2 bits; cnt[ch] is AVG_LOG2 bits; one pair per channel.
  - Register array or RAM with single-cycle read-modify-write.
- On sampleValid=1 and restart=0, with ch=sampleAddr and sum=acc[ch]+sampleData (full width, no overflow possible):
  - If cnt[ch] != 2^AVG_LOG2-1: acc[ch]<=sum, cnt[ch]<=cnt[ch]+1.
  - Else (completion): result = sum >> AVG_LOG2 (truncate, no rounding); acc[ch]<=0, cnt[ch]<=0.
- Completion and output register:
  - On completion, the result is offered to the output register in the same edge. Latency: avgValid rises on the clock edge after the completing sampleValid cycle (1 cycle).
  - Load rule: the register loads if it is empty, or is being popped this cycle (avgValid=1 and avgReady=1).
  - If avgValid=1 and avgReady=0 at completion: result is dropped, held result is unchanged, and overrun<=1. Channel acc/cnt are still cleared.
- Handshake:
  - A transfer occurs on any edge with avgValid=1 and avgReady=1.
  - Without a new load, avgValid<=0 after the transfer. avgData/avgAddr keep their last value after a pop.
  - avgData/avgAddr are stable while avgValid=1 and avgReady=0.
  - Pop and completion in the same cycle: the new result loads, avgValid stays 1, and no overrun.
- restart=1:
  - All acc/cnt cleared on the next edge.
  - A coincident sampleValid is discarded: restart wins and no completion occurs.
  - The output register and overrun are unaffected.
- overrun clears only on reset.
- Back-to-back samples:
  - sampleValid may be asserted every cycle, including the same channel on consecutive cycles.
  - The read-modify-write must use the updated value: no lost accumulation.
- Channels are independent; interleaved addresses accumulate separately.

Test Plan:
1. Ch 3 samples 100,101,102,103 with avgReady=1 -> one cycle after 4th strobe: avgValid=1 for 1 cycle, avgData=101 (406>>2), avgAddr=3.
2. Interleave ch 0 (10,10,10,10) and ch 31 (4095 x4), alternating every cycle -> two results: ch0=10, ch31=4095. No overflow, no cross-talk.
3. avgReady=0; complete ch 1 (all 8), then ch 2 (all 16) -> avgData=8/avgAddr=1 held stable, overrun=1, ch 2 result lost. Raise avgReady -> one transfer, then avgValid=0.
4. Hold result for ch 5; pulse avgReady in the same cycle as the ch 6 completion (values 40 x4) -> avgData=40, avgAddr=6, avgValid stays 1, overrun=0.
5. Ch 7 gets two samples; restart with a coincident third sample; then four samples of 200 -> single result 200. No result from the pre-restart samples.
6. Assert reset after 3 samples on ch 4 (one cycle also holding avgValid=1) -> all outputs 0 immediately. Four post-reset samples of 50 yield exactly 50.
